// File: rtl/spike_result_reader.sv
// Purpose: drains output-layer spike indices, counts spikes per class and reports the argmax after NUM_TIMESTEP EOT tokens; define SPIKE_RD_ERR_EN for a sticky err on out-of-range ids.
// Latency: result_valid rises NUM_CLASS+1 cycles after the final EOT word is valid (rd_vld).
// Backpressure: at most one read in flight (one word per 2 cycles), stalls while fifo_empty; result is a one-cycle pulse with no ready.
module spike_result_reader #(
    parameter int IDX_W        = 16,
    parameter int NUM_CLASS    = 10,
    parameter int CNT_W        = 8,
    parameter int NUM_TIMESTEP = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic             rd_en,
    input  logic [IDX_W-1:0] rd_data,
    input  logic             fifo_empty,
    output logic             result_valid,
    output logic [3:0]       result_class,
    output logic [CNT_W-1:0] result_count,
    output logic             err
);
    localparam int              TS_W     = $clog2(NUM_TIMESTEP + 1);
    localparam logic [3:0]      LAST_CLS = 4'(NUM_CLASS - 1);
    localparam logic [TS_W-1:0] LAST_TS  = TS_W'(NUM_TIMESTEP - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_ARG, S_DONE} state_t;

    state_t           state_q, state_d;
    logic             rd_vld;
    logic [CNT_W-1:0] count [NUM_CLASS];
    logic [TS_W-1:0]  ts_cnt;
    logic [3:0]       scan_idx, best_cls;
    logic [CNT_W-1:0] best_cnt;

    logic             is_eot, id_ok, last_eot, scan_gt, unused_bits;
    logic [9:0]       word_id;

    assign is_eot      = rd_data[IDX_W-1];
    assign word_id     = rd_data[9:0];
    assign id_ok       = word_id < 10'(NUM_CLASS);
    assign last_eot    = rd_vld && is_eot && (ts_cnt == LAST_TS);
    assign scan_gt     = count[scan_idx] > best_cnt;
    assign unused_bits = ^rd_data[IDX_W-2:10];

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        rd_en        = 1'b0;
        result_valid = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_RUN;
            S_RUN: begin
                // rd_vld doubles as the in-flight marker, so reads stop by themselves on the final EOT
                rd_en = !fifo_empty && !rd_vld;
                if (last_eot) state_d = S_ARG;
            end
            S_ARG: if (scan_idx == LAST_CLS) state_d = S_DONE;
            S_DONE: begin
                result_valid = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld       <= 1'b0;
            ts_cnt       <= '0;
            scan_idx     <= '0;
            best_cls     <= '0;
            best_cnt     <= '0;
            result_class <= '0;
            result_count <= '0;
            for (int i = 0; i < NUM_CLASS; i++) count[i] <= '0;
        end else begin
            rd_vld <= rd_en;
            case (state_q)
                S_IDLE: begin
                    ts_cnt <= '0;
                    for (int i = 0; i < NUM_CLASS; i++) count[i] <= '0;
                end
                S_RUN: begin
                    scan_idx <= '0;
                    best_cls <= '0;
                    best_cnt <= '0;
                    if (rd_vld) begin
                        if (is_eot)
                            ts_cnt <= ts_cnt + 1'b1;
                        else if (id_ok && count[word_id[3:0]] != '1)
                            count[word_id[3:0]] <= count[word_id[3:0]] + 1'b1;
                    end
                end
                S_ARG: begin
                    // strict greater-than keeps the lowest index on ties
                    if (scan_gt) begin
                        best_cls <= scan_idx;
                        best_cnt <= count[scan_idx];
                    end
                    scan_idx <= scan_idx + 1'b1;
                    if (scan_idx == LAST_CLS) begin
                        result_class <= scan_gt ? scan_idx : best_cls;
                        result_count <= scan_gt ? count[scan_idx] : best_cnt;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SPIKE_RD_ERR_EN
    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else if (state_q == S_RUN && rd_vld && !is_eot && !id_ok)
            err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_spike_result_reader.sv
module tb_spike_result_reader;
    localparam int IDX_W = 16, NUM_CLASS = 10, CNT_W = 8, NUM_TS = 4;
    localparam int PERIOD = 10;

    logic             clk, rst, rd_en, fifo_empty, result_valid, err;
    logic [IDX_W-1:0] rd_data;
    logic [3:0]       result_class;
    logic [CNT_W-1:0] result_count;

    spike_result_reader #(.IDX_W(IDX_W), .NUM_CLASS(NUM_CLASS), .CNT_W(CNT_W), .NUM_TIMESTEP(NUM_TS)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_data(rd_data), .fifo_empty(fifo_empty),
        .result_valid(result_valid), .result_class(result_class), .result_count(result_count), .err(err)
    );

    typedef struct { int cls; int cnt; } exp_t;

    exp_t             exp_q[$];
    logic [IDX_W-1:0] fq[$];
    int               hits [NUM_CLASS];
    int               tests = 0, fails = 0;
    int               viol = 0, eot_seen = 0;
    time              last_eot_t = 0;
    bit               toggle_mode = 0;
    int               last_cls = 0, last_cnt = 0;

    initial begin
        clk = 0;
        forever #(PERIOD/2) clk = ~clk;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // FIFO model: empty flag settles first, then a visible rd_en pops the word for the next cycle
    initial begin
        int cyc = 0;
        fifo_empty = 1'b1;
        rd_data    = '0;
        forever begin
            @(negedge clk);
            cyc++;
            fifo_empty = (fq.size() == 0) || (toggle_mode && ((cyc / 3) % 2 == 1));
            #1;
            if (rd_en === 1'b1) begin
                if (fifo_empty) viol++;
                if (fq.size() > 0) begin
                    rd_data = fq.pop_front();
                    if (rd_data[IDX_W-1]) begin
                        eot_seen++;
                        if (eot_seen == NUM_TS) begin
                            eot_seen   = 0;
                            last_eot_t = $time - 1;
                        end
                    end
                end
            end
        end
    end

    // Monitor: every result pulse must match the oldest expected inference
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (result_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got class %0d count %0d expected no pulse",
                             result_class, result_count);
                end else begin
                    e = exp_q.pop_front();
                    chk("result_class", result_class, e.cls);
                    chk("result_count", result_count, e.cnt);
                    chk("latency", ($time - last_eot_t) / PERIOD, NUM_CLASS + 2);
                end
            end
        end
    end

    function automatic logic [IDX_W-1:0] data_word(input int id);
        logic [4:0] junk = 5'($urandom);
        return {1'b0, junk, 10'(id)};
    endfunction

    function automatic logic [IDX_W-1:0] eot_word();
        logic [14:0] junk = 15'($urandom);
        return {1'b1, junk};
    endfunction

    task automatic clear_hits();
        for (int c = 0; c < NUM_CLASS; c++) hits[c] = 0;
    endtask

    // Reference: saturated counts, winner = lowest class holding the maximum
    task automatic run_inference(input string name, input int bad_cnt);
        int ids[$];
        int n_eot, mx, cls, tmp, j;
        exp_t e;
        for (int c = 0; c < NUM_CLASS; c++)
            for (int k = 0; k < hits[c]; k++) ids.push_back(c);
        for (int b = 0; b < bad_cnt; b++)
            ids.push_back(b == 0 ? 12 : int'($urandom_range(NUM_CLASS, 1023)));
        for (int i = ids.size() - 1; i > 0; i--) begin
            j      = $urandom_range(0, i);
            tmp    = ids[i];
            ids[i] = ids[j];
            ids[j] = tmp;
        end
        mx = 0;
        for (int c = 0; c < NUM_CLASS; c++)
            if ((hits[c] > 255 ? 255 : hits[c]) > mx) mx = (hits[c] > 255 ? 255 : hits[c]);
        cls = 0;
        for (int c = NUM_CLASS - 1; c >= 0; c--)
            if ((hits[c] > 255 ? 255 : hits[c]) == mx) cls = c;
        e.cls = cls;
        e.cnt = mx;
        @(posedge clk);
        exp_q.push_back(e);
        n_eot = 0;
        foreach (ids[i]) begin
            fq.push_back(data_word(ids[i]));
            if (n_eot < NUM_TS - 1 && $urandom_range(0, 3) == 0) begin
                fq.push_back(eot_word());
                n_eot++;
            end
        end
        while (n_eot < NUM_TS) begin
            fq.push_back(eot_word());
            n_eot++;
        end
        for (int k = 0; k < 6000 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no result expected class %0d count %0d", name, cls, mx);
            exp_q.delete();
        end
        last_cls = cls;
        last_cnt = mx;
        repeat (3) @(negedge clk);
        chk({name, "_hold_class"}, result_class, last_cls);
        chk({name, "_hold_count"}, result_count, last_cnt);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_result_class", result_class, 0);
        chk("rst_result_count", result_count, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;

        clear_hits();
        hits[1] = 3; hits[4] = 7; hits[9] = 2;
        run_inference("basic", 0);

        clear_hits();
        hits[2] = 5; hits[6] = 5;
        run_inference("tie", 0);

        clear_hits();
        hits[0] = 300;
        run_inference("saturate", 0);

        clear_hits();
        run_inference("all_zero", 0);

        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < NUM_CLASS; c++) hits[c] = $urandom_range(0, 12);
            run_inference("random", 0);
        end

        toggle_mode = 1;
        for (int c = 0; c < NUM_CLASS; c++) hits[c] = $urandom_range(0, 10);
        run_inference("toggle", 0);
        toggle_mode = 0;
        chk("no_read_while_empty", viol, 0);

        chk("err_before_bad", err, 0);
        for (int c = 0; c < NUM_CLASS; c++) hits[c] = $urandom_range(0, 8);
        run_inference("bad_id", 3);
`ifdef SPIKE_RD_ERR_EN
        chk("err_after_bad", err, 1);
`else
        chk("err_after_bad", err, 0);
`endif

        // abandoned inference: two full timesteps plus part of a third, then reset
        @(posedge clk);
        for (int t = 0; t < 2; t++) begin
            for (int k = 0; k < 4; k++) fq.push_back(data_word(5));
            fq.push_back(eot_word());
        end
        for (int k = 0; k < 3; k++) fq.push_back(data_word(5));
        for (int k = 0; k < 500 && fq.size() != 0; k++) @(negedge clk);
        chk("partial_drained", fq.size(), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        fq.delete();
        eot_seen = 0;
        chk("midrun_rst_err", err, 0);
        chk("midrun_rst_class", result_class, 0);
        rst = 1'b0;
        clear_hits();
        hits[3] = 4; hits[7] = 2;
        run_inference("post_reset", 0);

        chk("fifo_all_consumed", fq.size(), 0);
        chk("no_read_while_empty_final", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
